// File: rtl/mul_share_ctrl.sv
// Shares one shift-add/double-dabble multiplier between two requesters, round-robin arbitrated.
// Optional RUN watchdog is compiled in with `define MUL_SHARE_TIMEOUT_EN.
module mul_share_ctrl #(
    parameter int unsigned N        = 5,
    parameter int unsigned LOAD_CYC = 2,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic [N-1:0]             req0_a,
    input  logic [N-1:0]             req0_b,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [N-1:0]             req1_a,
    input  logic [N-1:0]             req1_b,
    output logic                     req1_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_id,
    output logic [2*N-1:0]           rsp_out,
    output logic [((2*N/3)+1)*4-1:0] rsp_bcd,
    output logic                     rsp_err,
    output logic [N-1:0]             mul_a,
    output logic [N-1:0]             mul_b,
    output logic                     mul_start,
    input  logic                     mul_finish,
    input  logic [2*N-1:0]           mul_out,
    input  logic [((2*N/3)+1)*4-1:0] mul_bcd
);
    localparam int unsigned PW  = 2 * N;
    localparam int unsigned BW  = ((2 * N / 3) + 1) * 4;
    localparam int unsigned LcW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StResp} state_e;

    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            id_q, id_d;
    logic [N-1:0]    a_q, a_d, b_q, b_d;
    logic [PW-1:0]   out_q, out_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [LcW-1:0]  load_cnt_q, load_cnt_d;
    logic            run_first_q, run_first_d;
    logic            grant0, grant1;

    // Parameter sanity; LOAD_CYC of 0 would skip the operand settling window.
    assert property (@(posedge clk) (LOAD_CYC >= 1) && (TIMEOUT >= 1));

    // Grant only from IDLE; when both ask, the one not served last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle && !reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

`ifdef MUL_SHARE_TIMEOUT_EN
    localparam int unsigned TmW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TmW-1:0] timer_q, timer_d;
    logic           err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        out_d        = out_q;
        bcd_d        = bcd_q;
        load_cnt_d   = load_cnt_q;
        run_first_d  = run_first_q;
`ifdef MUL_SHARE_TIMEOUT_EN
        timer_d      = timer_q;
        err_d        = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (grant0 || grant1) begin
                    id_d         = grant1;
                    last_grant_d = grant1;
                    a_d          = grant1 ? req1_a : req0_a;
                    b_d          = grant1 ? req1_b : req0_b;
                    load_cnt_d   = '0;
                    state_d      = StLoad;
                end
            end
            StLoad: begin
                if (load_cnt_q == LcW'(LOAD_CYC - 1)) begin
                    run_first_d = 1'b1;
`ifdef MUL_SHARE_TIMEOUT_EN
                    timer_d     = '0;
`endif
                    state_d     = StRun;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            StRun: begin
                run_first_d = 1'b0;
                // The finish flag may still be high from the previous job in the first cycle.
                if (!run_first_q && mul_finish) begin
                    out_d   = mul_out;
                    bcd_d   = mul_bcd;
                    state_d = StResp;
                end
`ifdef MUL_SHARE_TIMEOUT_EN
                else if (timer_q == TmW'(TIMEOUT - 1)) begin
                    out_d   = '0;
                    bcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            StResp: begin
                if (rsp_ready) begin
`ifdef MUL_SHARE_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            out_q        <= '0;
            bcd_q        <= '0;
            load_cnt_q   <= '0;
            run_first_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            out_q        <= out_d;
            bcd_q        <= bcd_d;
            load_cnt_q   <= load_cnt_d;
            run_first_q  <= run_first_d;
        end
    end

`ifdef MUL_SHARE_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign mul_start  = (state_q == StRun);
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_out    = out_q;
    assign rsp_bcd    = bcd_q;

endmodule
